// File: rtl/seq_barrel_shifter_if.sv
// Handshake/data bundle between an ALU sequencer and the multi-cycle shifter.
interface seq_barrel_shifter_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               start;
    logic [1:0]         op;
    logic [WIDTH-1:0]   data_in;
    logic [SHAMT_W-1:0] shamt;
    logic               in_ready;
    logic               busy;
    logic               result_valid;
    logic [WIDTH-1:0]   result;

    modport master (
        output start, op, data_in, shamt,
        input  in_ready, busy, result_valid, result
    );

    modport slave (
        input  start, op, data_in, shamt,
        output in_ready, busy, result_valid, result
    );
endinterface

// File: rtl/seq_barrel_shifter.sv
// Multi-cycle barrel shifter: one binary stage (shift by 2^k) per cycle,
// fixed latency of SHAMT_W+1 cycles from accept to result_valid.
// op: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
module seq_barrel_shifter #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input logic               clock,
    input logic               reset,
    seq_barrel_shifter_if.slave bus
);
    localparam int K_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, stateNext;
    logic [1:0]         opR;
    logic [WIDTH-1:0]   workR;
    logic [SHAMT_W-1:0] shamtR;
    logic               signR;
    logic [K_W-1:0]     stageCnt;
    logic [WIDTH-1:0]   resultR;

    logic               accept;
    logic               lastStage;
    logic [SHAMT_W-1:0] shAmt;
    logic [WIDTH-1:0]   shifted;
    logic [WIDTH-1:0]   stageOut;

    assign accept    = (state != RUN) && bus.start;
    assign lastStage = (stageCnt == K_W'(SHAMT_W - 1));

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic; a start in DONE re-enters RUN directly
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (bus.start) stateNext = RUN;
            RUN:     if (lastStage) stateNext = DONE;
            DONE:    stateNext = bus.start ? RUN : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        bus.in_ready     = (state != RUN);
        bus.busy         = (state == RUN);
        bus.result_valid = (state == DONE);
        bus.result       = resultR;
    end

    // One shift stage of 2^k; SRA fills from the captured original sign bit
    always_comb begin
        shAmt = SHAMT_W'(1) << stageCnt;
        case (opR)
            2'b00:   shifted = workR << shAmt;
            2'b01:   shifted = workR >> shAmt;
            2'b10:   shifted = (workR >> shAmt) | (signR ? ~({WIDTH{1'b1}} >> shAmt) : '0);
            default: shifted = (workR >> shAmt) | (workR << (WIDTH - int'(shAmt)));
        endcase
        stageOut = shamtR[stageCnt] ? shifted : workR;
    end

    // Working registers, stage counter and held result
    always_ff @(posedge clock) begin
        if (reset) begin
            opR      <= '0;
            workR    <= '0;
            shamtR   <= '0;
            signR    <= 1'b0;
            stageCnt <= '0;
            resultR  <= '0;
        end else if (accept) begin
            opR      <= bus.op;
            workR    <= bus.data_in;
            shamtR   <= bus.shamt;
            signR    <= bus.data_in[WIDTH-1];
            stageCnt <= '0;
        end else if (state == RUN) begin
            workR    <= stageOut;
            stageCnt <= stageCnt + K_W'(1);
            // result is loaded on the edge that enters DONE and then held
            if (lastStage) begin
                resultR <= stageOut;
            end
        end
    end
endmodule

// File: tb/tb_seq_barrel_shifter.sv
// Scoreboard bench for seq_barrel_shifter: stimulus pushes expected results,
// a negedge monitor pops and compares on every result_valid.
`timescale 1ns/1ps
module tb_seq_barrel_shifter;
    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    typedef struct {
        logic [31:0] res;
        int unsigned cyc;
        string       nm;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        sawReset = 1'b0;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] lastRes = '0;
    exp_t        sb[$];

    seq_barrel_shifter_if #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) bus ();

    seq_barrel_shifter #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc      <= cyc + 1;
        sawReset <= reset;
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    function automatic logic [31:0] refShift(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s);
        case (o)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return $unsigned($signed(d) >>> s);
            default: return (d >> s) | (d << (32 - int'(s)));
        endcase
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] d, input logic [4:0] s,
                         input logic [31:0] e, input string nm);
        int unsigned n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            check({nm, " in_ready timeout"}, 32'(bus.in_ready), 32'd1);
        end else begin
            bus.start   = 1'b1;
            bus.op      = o;
            bus.data_in = d;
            bus.shamt   = s;
            sb.push_back('{e, cyc + SHAMT_W + 1, nm});
            @(negedge clock);
            bus.start   = 1'b0;
            bus.op      = 2'($urandom);
            bus.data_in = $urandom;
            bus.shamt   = 5'($urandom);
        end
    endtask

    task automatic drain(input string nm);
        int unsigned n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) check({nm, " drain timeout"}, 32'(sb.size()), 32'd0);
    endtask

    // Monitor: result/latency on valid, hold otherwise, handshake consistency
    initial begin
        exp_t x;
        forever begin
            @(negedge clock);
            if (cyc != 0) begin
                if (sawReset) lastRes = '0;
                check("handshake", {29'd0, bus.in_ready, bus.busy, bus.result_valid},
                      {29'd0, ~bus.busy, bus.busy, bus.result_valid & ~bus.busy});
                if (bus.result_valid === 1'b1) begin
                    if (sawReset || sb.size() == 0) begin
                        check("unexpected result_valid", 32'd1, 32'd0);
                    end else begin
                        x = sb.pop_front();
                        check(x.nm, bus.result, x.res);
                        check({x.nm, " latency"}, cyc, x.cyc);
                    end
                    lastRes = bus.result;
                end else begin
                    check("result hold", bus.result, lastRes);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d want completion", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  o;
        logic [4:0]  s;
        logic [31:0] d;
        bus.start   = 1'b0;
        bus.op      = '0;
        bus.data_in = '0;
        bus.shamt   = '0;
        reset       = 1'b1;
        repeat (2) @(negedge clock);
        check("reset in_ready", 32'(bus.in_ready), 32'd1);
        check("reset busy", 32'(bus.busy), 32'd0);
        check("reset result_valid", 32'(bus.result_valid), 32'd0);
        check("reset result", bus.result, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // Directed vectors (back-to-back accepts in DONE happen naturally)
        issue(2'b10, 32'h8000_0000, 5'd2,  32'hE000_0000, "sra_neg_2");
        issue(2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, "sll_max");
        issue(2'b01, 32'hF000_0000, 5'd4,  32'h0F00_0000, "srl_4");
        issue(2'b10, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, "sra_pos_max");
        issue(2'b10, 32'h8000_0001, 5'd31, 32'hFFFF_FFFF, "sra_neg_max");
        issue(2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000, "ror_1");
        issue(2'b11, 32'h1234_5678, 5'd8,  32'h7812_3456, "ror_8");
        issue(2'b00, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFF0, "sll_4");
        issue(2'b00, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5, "sll_0");
        issue(2'b01, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5, "srl_0");
        issue(2'b10, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5, "sra_0");
        issue(2'b11, 32'hA5A5_A5A5, 5'd0,  32'hA5A5_A5A5, "ror_0");
        drain("directed");
        repeat (3) @(negedge clock);

        // start while busy must be ignored
        issue(2'b01, 32'h0000_00F0, 5'd4, 32'h0000_000F, "srl_busy");
        @(negedge clock);
        bus.start   = 1'b1;
        bus.op      = 2'b00;
        bus.data_in = 32'hFFFF_FFFF;
        bus.shamt   = 5'd1;
        @(negedge clock);
        bus.start   = 1'b0;
        drain("busy");
        repeat (8) @(negedge clock);

        // reset mid-RUN: aborts with no result
        bus.start   = 1'b1;
        bus.op      = 2'b01;
        bus.data_in = 32'hDEAD_BEEF;
        bus.shamt   = 5'd3;
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort in_ready", 32'(bus.in_ready), 32'd1);
        check("abort busy", 32'(bus.busy), 32'd0);
        check("abort result", bus.result, 32'd0);
        check("abort result_valid", 32'(bus.result_valid), 32'd0);
        repeat (10) @(negedge clock);

        // Random ops against a single-shot reference shift
        for (int i = 0; i < 10000; i++) begin
            o = 2'($urandom_range(0, 3));
            d = $urandom;
            s = (i % 8 == 0) ? 5'd0 : (i % 8 == 1) ? 5'd31 : 5'($urandom_range(0, 31));
            issue(o, d, s, refShift(o, d, s), "rand");
        end
        drain("random");
        repeat (4) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
